// File: rtl/gnr_pkg.sv
// Package: gnr_pkg
// Shared definitions for the Boolean gene-network attractor finder and its node cells.
// Provides the sequencer state encoding and the default network/counter dimensions.
package gnr_pkg;

  // Default dimensions shared by the node cells and the top level.
  localparam int unsigned NNodesDefault   = 16;
  localparam int unsigned CntWDefault     = 16;
  localparam int unsigned MaxStepsDefault = 4096;

  // Sequencer states. Each search or period step takes one STEP cycle followed by one CHK cycle.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S_STEP,
    S_CHK,
    P_STEP,
    P_CHK,
    DONE
  } gnr_state_e;

endpackage

// File: rtl/gnr_attractor_finder.sv
// Module: gnr_attractor_finder
// Sequences a network of per-node state cells through Floyd cycle detection. Each cell holds
// a tortoise copy (s0, advances on every other start_s0 pulse) and a hare copy (s1, advances on
// every start_s1 pulse). After loading init_vec the cells are stepped until s0_vec == s1_vec on
// an even step; the tortoise is then frozen and the hare stepped alone to measure the period.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start           1-cycle request, sampled only while idle
//   init_vec        initial network state, latched on accepted start
//   s0_vec, s1_vec  registered tortoise / hare outputs of all nodes
//   reset_nos       load init_state into all nodes and re-arm the tortoise pass bit
//   init_state      latched init_vec driven to all nodes
//   start_s0/_s1    tortoise / hare step enables, broadcast to all nodes
//   busy            high in every state except idle
//   done            1-cycle completion pulse; result ports valid from this cycle
//   timeout         sticky abort flag, cleared by the next accepted start
//   steps           hare steps taken when tortoise met hare
//   period          attractor cycle length, 0 on timeout
//   attractor       s0_vec captured at the meet point
module gnr_attractor_finder
  import gnr_pkg::*;
#(
  parameter int unsigned N_NODES   = NNodesDefault,
  parameter int unsigned CNT_W     = CntWDefault,
  parameter int unsigned MAX_STEPS = MaxStepsDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   steps,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attractor
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] TwoCnt = CNT_W'(2);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  gnr_state_e         state_q, state_d;
  logic [N_NODES-1:0] init_q, init_d;
  logic [N_NODES-1:0] attractor_q, attractor_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               timeout_q, timeout_d;

  logic               vec_equal;
  logic               hare_home;
  logic               even_meet;

  assign vec_equal = (s0_vec == s1_vec);
  assign hare_home = (s1_vec == attractor_q);
  // Step 1 always looks like a meet (both copies took exactly one step), so only even
  // step counts of at least 2 qualify.
  assign even_meet = vec_equal && !steps_q[0] && (steps_q >= TwoCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      init_q      <= '0;
      attractor_q <= '0;
      steps_q     <= '0;
      period_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      attractor_q <= attractor_d;
      steps_q     <= steps_d;
      period_q    <= period_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    attractor_d = attractor_q;
    steps_d     = steps_q;
    period_d    = period_q;
    timeout_d   = timeout_q;
    reset_nos   = 1'b0;
    start_s0    = 1'b0;
    start_s1    = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          init_d    = init_vec;
          steps_d   = '0;
          period_d  = '0;
          timeout_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        reset_nos = 1'b1;
        state_d   = S_STEP;
      end
      S_STEP: begin
        start_s0 = 1'b1;
        start_s1 = 1'b1;
        steps_d  = steps_q + OneCnt;
        state_d  = S_CHK;
      end
      S_CHK: begin
        if (even_meet) begin
          attractor_d = s0_vec;
          state_d     = P_STEP;
        end else if (steps_q == MaxCnt) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      P_STEP: begin
        // Tortoise stays frozen on the attractor while the hare walks the cycle.
        start_s1 = 1'b1;
        period_d = period_q + OneCnt;
        state_d  = P_CHK;
      end
      P_CHK: begin
        if (hare_home) begin
          state_d = DONE;
        end else if (period_q == MaxCnt) begin
          timeout_d = 1'b1;
          period_d  = '0;
          state_d   = DONE;
        end else begin
          state_d = P_STEP;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign init_state = init_q;
  assign timeout    = timeout_q;
  assign steps      = steps_q;
  assign period     = period_q;
  assign attractor  = attractor_q;

endmodule

// File: tb/tb_gnr_attractor_finder.sv
// Testbench: tb_gnr_attractor_finder
// Two finder instances, each driving a behavioural node network: dut_a uses the default
// MAX_STEPS, dut_b uses MAX_STEPS=8. Expected results are pushed to a scoreboard when a run is
// launched and popped when done is observed.
module tb_gnr_attractor_finder;
  import gnr_pkg::*;

  localparam int unsigned NN     = 16;
  localparam int unsigned CW     = 16;
  localparam int          Budget = 400;

  typedef struct {
    logic [CW-1:0] steps;
    logic [CW-1:0] period;
    logic [NN-1:0] att;
    logic          to;
    int            lat;
    bit            chk_att;
  } exp_t;

  exp_t sb[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic [NN-1:0] init_a = '0, init_b = '0;
  logic [NN-1:0] s0_a, s1_a, s0_b, s1_b;
  logic          pass_a, pass_b;
  logic          reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a;
  logic          reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b;
  logic [NN-1:0] init_state_a, attractor_a, init_state_b, attractor_b;
  logic [CW-1:0] steps_a, period_a, steps_b, period_b;

  int            sel_a = 0;
  int            sel_b = 3;

  int            n_checks = 0;
  int            n_fail   = 0;

  // Values sampled at the done cycle and one cycle later.
  logic [CW-1:0] got_steps, got_period;
  logic [NN-1:0] got_att;
  logic          got_to, got_done_after, got_busy_after;

  always #5 clk = ~clk;

  gnr_attractor_finder #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(4096)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .init_vec(init_a), .s0_vec(s0_a), .s1_vec(s1_a),
    .reset_nos(reset_nos_a), .init_state(init_state_a), .start_s0(start_s0_a),
    .start_s1(start_s1_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .steps(steps_a), .period(period_a), .attractor(attractor_a)
  );

  gnr_attractor_finder #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .init_vec(init_b), .s0_vec(s0_b), .s1_vec(s1_b),
    .reset_nos(reset_nos_b), .init_state(init_state_b), .start_s0(start_s0_b),
    .start_s1(start_s1_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .steps(steps_b), .period(period_b), .attractor(attractor_b)
  );

  // Network transfer functions: 0 identity, 1 3-node ring, 2 transient-2 into 4-cycle,
  // 3 16-bit counter.
  function automatic logic [NN-1:0] net_f(input int sel, input logic [NN-1:0] x);
    logic [NN-1:0] r;
    case (sel)
      0:       r = x;
      1:       r = {13'b0, x[1:0], x[2]};
      2:       r = (x < 16'd5) ? x + 16'd1 : 16'd2;
      default: r = x + 16'd1;
    endcase
    return r;
  endfunction

  // Behavioural node cells; the tortoise moves on the first of each pair of start_s0 pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_a <= '0; s1_a <= '0; pass_a <= 1'b0;
    end else if (reset_nos_a) begin
      s0_a <= init_state_a; s1_a <= init_state_a; pass_a <= 1'b0;
    end else begin
      if (start_s1_a) s1_a <= net_f(sel_a, s1_a);
      if (start_s0_a) begin
        if (!pass_a) s0_a <= net_f(sel_a, s0_a);
        pass_a <= ~pass_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_b <= '0; s1_b <= '0; pass_b <= 1'b0;
    end else if (reset_nos_b) begin
      s0_b <= init_state_b; s1_b <= init_state_b; pass_b <= 1'b0;
    end else begin
      if (start_s1_b) s1_b <= net_f(sel_b, s1_b);
      if (start_s0_b) begin
        if (!pass_b) s0_b <= net_f(sel_b, s0_b);
        pass_b <= ~pass_b;
      end
    end
  end

  // Abstract Floyd model on state sequences. Latency counts clock edges from the edge that
  // accepts start to the first sample where done is visible.
  function automatic exp_t model_run(input int sel, input logic [NN-1:0] iv, input int max_s);
    exp_t          e;
    logic [NN-1:0] t, h;
    bit            pass, met, home;
    int            s, p;
    t = iv; h = iv; pass = 0; met = 0; home = 0; s = 0; p = 0;
    while (!met && s < max_s) begin
      s++;
      h = net_f(sel, h);
      if (!pass) t = net_f(sel, t);
      pass = !pass;
      if ((s % 2) == 0 && t == h) met = 1;
    end
    e.steps = CW'(s); e.att = t; e.chk_att = met; e.to = !met; e.period = '0;
    if (met) begin
      while (!home && p < max_s) begin
        p++;
        h = net_f(sel, h);
        if (h == t) home = 1;
      end
      e.to     = !home;
      e.period = home ? CW'(p) : '0;
    end
    e.lat = 2 + 2 * s + 2 * p;
    return e;
  endfunction

  // Launches a run on dut_a (which=0) or dut_b (which=1) and waits for done. start is
  // re-pulsed on dut_a between cycles pf..pt after acceptance.
  task automatic launch(input bit which, input logic [NN-1:0] iv, input int pf, input int pt,
                        output bit seen, output int lat);
    seen = 0;
    lat  = 0;
    @(negedge clk);
    if (which) begin start_b = 1'b1; init_b = iv; end
    else       begin start_a = 1'b1; init_a = iv; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int cyc = 1; cyc <= Budget; cyc++) begin
      if ((which ? done_b : done_a) === 1'b1) begin
        seen       = 1;
        lat        = cyc;
        got_steps  = which ? steps_b : steps_a;
        got_period = which ? period_b : period_a;
        got_att    = which ? attractor_b : attractor_a;
        got_to     = which ? timeout_b : timeout_a;
        break;
      end
      if (!which) start_a = (cyc >= pf && cyc <= pt);
      @(negedge clk);
    end
    start_a = 1'b0;
    if (seen) begin
      @(negedge clk);
      got_done_after = which ? done_b : done_a;
      got_busy_after = which ? busy_b : busy_a;
    end
  endtask

  task automatic test_reset();
    logic [79:0] outs_a, outs_b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs_a = {reset_nos_a, init_state_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a,
              steps_a, period_a, attractor_a, 10'b0};
    outs_b = {reset_nos_b, init_state_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b,
              steps_b, period_b, attractor_b, 10'b0};
    n_checks++;
    if (outs_a !== '0) begin
      n_fail++; $display("FAIL reset_outputs_a: got %h required 0", outs_a);
    end
    n_checks++;
    if (outs_b !== '0) begin
      n_fail++; $display("FAIL reset_outputs_b: got %h required 0", outs_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Compares the sampled done-cycle results against the next scoreboard entry.
  task automatic test_identity();
    exp_t e;
    bit   seen;
    int   lat;
    sel_a = 0;
    sb.push_back('{steps: 16'd2, period: 16'd1, att: 16'h00A5, to: 1'b0, lat: 8, chk_att: 1});
    launch(0, 16'h00A5, 0, -1, seen, lat);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL identity_done: no done within budget"); end
    else begin
      n_checks += 6;
      if (lat != e.lat) begin n_fail++;
        $display("FAIL identity_latency: got %0d required %0d", lat, e.lat); end
      if (got_steps !== e.steps) begin n_fail++;
        $display("FAIL identity_steps: got %0d required %0d", got_steps, e.steps); end
      if (got_period !== e.period) begin n_fail++;
        $display("FAIL identity_period: got %0d required %0d", got_period, e.period); end
      if (got_att !== e.att) begin n_fail++;
        $display("FAIL identity_attractor: got %h required %h", got_att, e.att); end
      if (got_to !== e.to) begin n_fail++;
        $display("FAIL identity_timeout: got %b required %b", got_to, e.to); end
      if (got_done_after !== 1'b0 || got_busy_after !== 1'b0) begin n_fail++;
        $display("FAIL identity_done_pulse: done/busy after got %b%b required 00",
                 got_done_after, got_busy_after); end
    end
  endtask

  task automatic test_ring(input int pf, input int pt, input string tag);
    exp_t e;
    bit   seen;
    int   lat;
    sel_a = 1;
    sb.push_back('{steps: 16'd6, period: 16'd3, att: 16'h0001, to: 1'b0, lat: 20, chk_att: 1});
    launch(0, 16'h0001, pf, pt, seen, lat);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s_done: no done within budget", tag); end
    else begin
      n_checks += 5;
      if (lat != e.lat) begin n_fail++;
        $display("FAIL %s_latency: got %0d required %0d", tag, lat, e.lat); end
      if (got_steps !== e.steps) begin n_fail++;
        $display("FAIL %s_steps: got %0d required %0d", tag, got_steps, e.steps); end
      if (got_period !== e.period) begin n_fail++;
        $display("FAIL %s_period: got %0d required %0d", tag, got_period, e.period); end
      if (got_att !== e.att) begin n_fail++;
        $display("FAIL %s_attractor: got %h required %h", tag, got_att, e.att); end
      if (got_to !== e.to) begin n_fail++;
        $display("FAIL %s_timeout: got %b required %b", tag, got_to, e.to); end
    end
  endtask

  task automatic test_chain();
    exp_t e;
    bit   seen;
    int   lat;
    sel_a = 2;
    sb.push_back(model_run(2, 16'h0000, 4096));
    launch(0, 16'h0000, 0, -1, seen, lat);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL chain_done: no done within budget"); end
    else begin
      n_checks += 6;
      if (lat != e.lat) begin n_fail++;
        $display("FAIL chain_latency: got %0d required %0d", lat, e.lat); end
      if (got_steps !== e.steps || got_steps[0] !== 1'b0) begin n_fail++;
        $display("FAIL chain_steps: got %0d required %0d (even)", got_steps, e.steps); end
      if (got_period !== 16'd4 || got_period !== e.period) begin n_fail++;
        $display("FAIL chain_period: got %0d required 4", got_period); end
      if (got_att !== e.att) begin n_fail++;
        $display("FAIL chain_attractor: got %h required %h", got_att, e.att); end
      if (got_att < 16'd2 || got_att > 16'd5) begin n_fail++;
        $display("FAIL chain_on_cycle: got %h required 2..5", got_att); end
      if (got_to !== 1'b0) begin n_fail++;
        $display("FAIL chain_timeout: got %b required 0", got_to); end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   seen;
    int   lat;
    sb.push_back('{steps: 16'd8, period: 16'd0, att: 16'h0000, to: 1'b1, lat: 18, chk_att: 0});
    launch(1, 16'h0000, 0, -1, seen, lat);
    e = sb.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL timeout_done: no done within budget"); end
    else begin
      n_checks += 5;
      if (lat != e.lat) begin n_fail++;
        $display("FAIL timeout_latency: got %0d required %0d", lat, e.lat); end
      if (got_steps !== e.steps) begin n_fail++;
        $display("FAIL timeout_steps: got %0d required %0d", got_steps, e.steps); end
      if (got_period !== e.period) begin n_fail++;
        $display("FAIL timeout_period: got %0d required %0d", got_period, e.period); end
      if (got_to !== e.to) begin n_fail++;
        $display("FAIL timeout_flag: got %b required %b", got_to, e.to); end
      // Flag must stay set after the done pulse.
      if (timeout_b !== 1'b1) begin n_fail++;
        $display("FAIL timeout_sticky: got %b required 1", timeout_b); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit   found;
    bit   saw_done;
    exp_t e;
    bit   seen;
    int   lat;
    sel_a = 2;
    found = 0;
    saw_done = 0;
    @(negedge clk);
    start_a = 1'b1;
    init_a  = 16'h0000;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < Budget; cyc++) begin
      if (start_s1_a === 1'b1 && start_s0_a === 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rst_mid_pstep: never reached hare-only step"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({reset_nos_a, init_state_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a,
         steps_a, period_a, attractor_a} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy=%b steps=%0d period=%0d att=%h required all 0",
               busy_a, steps_a, period_a, attractor_a);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL rst_mid_idle: done/busy got 1 required 0"); end
    sb.push_back(model_run(2, 16'h0000, 4096));
    launch(0, 16'h0000, 0, -1, seen, lat);
    e = sb.pop_front();
    n_checks++;
    if (!seen || got_steps !== e.steps || got_period !== e.period || got_att !== e.att ||
        got_to !== e.to || lat != e.lat) begin
      n_fail++;
      $display("FAIL rst_mid_rerun: got seen=%b steps=%0d period=%0d att=%h to=%b lat=%0d required steps=%0d period=%0d att=%h to=%b lat=%0d",
               seen, got_steps, got_period, got_att, got_to, lat,
               e.steps, e.period, e.att, e.to, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ring(0, -1, "ring");
    test_chain();
    test_timeout();
    test_ring(2, 14, "restart_ignored");
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
